ospi_host_seq: RTL and testbench

Command sequencer that sits directly upstream of the OSPI flash model. It accepts byte-burst read, write and erase commands on a valid/ready interface. It drives the flash-side chip select, the per-byte operation strobes, the address and the write data, and it returns read bytes on a valid/ready stream. CS setup time, minimum CS-high (deselect) time and address auto-increment are enforced here, so the flash only ever sees single-cycle, mutually exclusive strobes.

---
 rtl/ospi_host_seq_if.sv | 56 +++++
 rtl/ospi_host_seq.sv | 241 ++++++++++++++++++++++++
 tb/tb_ospi_host_seq.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ospi_host_seq_if.sv
// Host-side bundle for ospi_host_seq: command, write and read streams + status.
// master = command source / data producer-consumer, slave = the sequencer.
interface ospi_host_seq_if;
   // command channel
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_addr;
   logic [3:0] cmd_len;
   // write byte stream (host -> sequencer)
   logic [7:0] wr_data;
   logic       wr_valid;
   logic       wr_ready;
   // read byte stream (sequencer -> host)
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_ready;
   // status
   logic       busy;
   logic       done;
   logic       err;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_addr,
      output cmd_len,
      output wr_data,
      output wr_valid,
      output rd_ready,
      input  cmd_ready,
      input  wr_ready,
      input  rd_data,
      input  rd_valid,
      input  busy,
      input  done,
      input  err
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_addr,
      input  cmd_len,
      input  wr_data,
      input  wr_valid,
      input  rd_ready,
      output cmd_ready,
      output wr_ready,
      output rd_data,
      output rd_valid,
      output busy,
      output done,
      output err
   );
endinterface

// File: rtl/ospi_host_seq.sv
// OSPI command sequencer: turns byte-burst read/write/erase commands into
// single-cycle flash strobes with CS setup, CS-high and address increment.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   bus (slave)         cmd / wr / rd valid-ready streams, busy/done/err
//   o_flash_cs_n        flash chip select, active low
//   o_flash_we/re/ee    one-cycle write / read / erase strobes
//   o_flash_addr/din    flash byte address and write data
//   i_flash_dout        flash read data (registered inside the flash)
module ospi_host_seq #(
   parameter int CS_SETUP = 1,
   parameter int CS_HIGH  = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   ospi_host_seq_if.slave       bus,
   output logic                 o_flash_cs_n,
   output logic                 o_flash_we,
   output logic                 o_flash_re,
   output logic                 o_flash_ee,
   output logic [7:0]           o_flash_addr,
   output logic [7:0]           o_flash_din,
   input  logic [7:0]           i_flash_dout
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_SETUP,
      S_WR_WAIT,
      S_WR_STRB,
      S_RD_STRB,
      S_RD_CAP,
      S_RD_OUT,
      S_ER_STRB,
      S_DESEL
   } state_t;

   localparam logic [1:0] OP_RD  = 2'b00;
   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_RSV = 2'b11;

   // Delay counters load N-1 so the state lasts exactly N cycles.
   localparam logic [7:0] SETUP_LD = 8'(CS_SETUP - 1);
   localparam logic [7:0] HIGH_LD  = 8'(CS_HIGH - 1);

   state_t     r_state;
   logic [1:0] r_op;
   logic [7:0] r_addr;
   logic [4:0] r_cnt;
   logic [7:0] r_dly;
   logic [7:0] r_din;
   logic [7:0] r_rdata;
   logic       r_err;

   state_t     w_state_nxt;
   logic [1:0] w_op_nxt;
   logic [7:0] w_addr_nxt;
   logic [4:0] w_cnt_nxt;
   logic [7:0] w_dly_nxt;
   logic [7:0] w_din_nxt;
   logic [7:0] w_rdata_nxt;
   logic       w_err_nxt;

   logic       w_cmd_ready;
   logic       w_wr_ready;
   logic       w_rd_valid;
   logic       w_done;
   logic       w_cs_n;
   logic       w_we;
   logic       w_re;
   logic       w_ee;
   logic       w_last;

   // Per-byte loop entry for the latched operation.
   function automatic state_t f_byte_state(input logic [1:0] op);
      state_t s;
      unique case (op)
         OP_RD:   s = S_RD_STRB;
         OP_WR:   s = S_WR_WAIT;
         default: s = S_ER_STRB;
      endcase
      return s;
   endfunction

   assign w_last = (r_cnt == 5'd1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_op    <= 2'b00;
         r_addr  <= 8'h00;
         r_cnt   <= 5'd0;
         r_dly   <= 8'h00;
         r_din   <= 8'h00;
         r_rdata <= 8'h00;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_op    <= w_op_nxt;
         r_addr  <= w_addr_nxt;
         r_cnt   <= w_cnt_nxt;
         r_dly   <= w_dly_nxt;
         r_din   <= w_din_nxt;
         r_rdata <= w_rdata_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_op_nxt    = r_op;
      w_addr_nxt  = r_addr;
      w_cnt_nxt   = r_cnt;
      w_dly_nxt   = r_dly;
      w_din_nxt   = r_din;
      w_rdata_nxt = r_rdata;
      w_err_nxt   = 1'b0;
      w_cmd_ready = 1'b0;
      w_wr_ready  = 1'b0;
      w_rd_valid  = 1'b0;
      w_done      = 1'b0;
      w_cs_n      = 1'b0;
      w_we        = 1'b0;
      w_re        = 1'b0;
      w_ee        = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            w_cs_n      = 1'b1;
            w_cmd_ready = 1'b1;
            if (bus.cmd_valid) begin
               if (bus.cmd_op == OP_RSV) begin
                  // Reserved op: flag it, never touch the flash.
                  w_err_nxt = 1'b1;
               end else begin
                  w_op_nxt    = bus.cmd_op;
                  w_addr_nxt  = bus.cmd_addr;
                  w_cnt_nxt   = {1'b0, bus.cmd_len} + 5'd1;
                  w_dly_nxt   = SETUP_LD;
                  w_state_nxt = S_SETUP;
               end
            end
         end

         S_SETUP: begin
            if (r_dly == 8'h00) begin
               w_state_nxt = f_byte_state(r_op);
            end else begin
               w_dly_nxt = r_dly - 8'h01;
            end
         end

         S_WR_WAIT: begin
            w_wr_ready = 1'b1;
            if (bus.wr_valid) begin
               w_din_nxt   = bus.wr_data;
               w_state_nxt = S_WR_STRB;
            end
         end

         S_WR_STRB: begin
            w_we       = 1'b1;
            w_addr_nxt = r_addr + 8'h01;
            w_cnt_nxt  = r_cnt - 5'd1;
            if (w_last) begin
               w_dly_nxt   = HIGH_LD;
               w_state_nxt = S_DESEL;
            end else begin
               w_state_nxt = S_WR_WAIT;
            end
         end

         S_RD_STRB: begin
            w_re        = 1'b1;
            w_state_nxt = S_RD_CAP;
         end

         S_RD_CAP: begin
            // Flash registered the byte on the RD_STRB edge.
            w_rdata_nxt = i_flash_dout;
            w_state_nxt = S_RD_OUT;
         end

         S_RD_OUT: begin
            w_rd_valid = 1'b1;
            if (bus.rd_ready) begin
               w_addr_nxt = r_addr + 8'h01;
               w_cnt_nxt  = r_cnt - 5'd1;
               if (w_last) begin
                  w_dly_nxt   = HIGH_LD;
                  w_state_nxt = S_DESEL;
               end else begin
                  w_state_nxt = S_RD_STRB;
               end
            end
         end

         S_ER_STRB: begin
            w_ee       = 1'b1;
            w_addr_nxt = r_addr + 8'h01;
            w_cnt_nxt  = r_cnt - 5'd1;
            if (w_last) begin
               w_dly_nxt   = HIGH_LD;
               w_state_nxt = S_DESEL;
            end
         end

         S_DESEL: begin
            w_cs_n = 1'b1;
            // Counter still at its load value only in the first cycle.
            w_done = (r_dly == HIGH_LD);
            if (r_dly == 8'h00) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_dly_nxt = r_dly - 8'h01;
            end
         end

         default: begin
            w_cs_n      = 1'b1;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign bus.cmd_ready = w_cmd_ready;
   assign bus.wr_ready  = w_wr_ready;
   assign bus.rd_valid  = w_rd_valid;
   assign bus.rd_data   = r_rdata;
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.done      = w_done;
   assign bus.err       = r_err;

   assign o_flash_cs_n  = w_cs_n;
   assign o_flash_we    = w_we;
   assign o_flash_re    = w_re;
   assign o_flash_ee    = w_ee;
   assign o_flash_addr  = r_addr;
   assign o_flash_din   = r_din;

endmodule

// File: tb/tb_ospi_host_seq.sv
// Directed bench for ospi_host_seq with a behavioural flash model,
// a write-byte feeder and a read-byte consumer with optional stalls.
module tb_ospi_host_seq;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   ospi_host_seq_if bus();

   logic       cs_n, we, re, ee;
   logic [7:0] faddr, fdin;
   logic [7:0] fdout = 8'h00;

   ospi_host_seq #(.CS_SETUP(1), .CS_HIGH(2)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .bus          (bus),
      .o_flash_cs_n (cs_n),
      .o_flash_we   (we),
      .o_flash_re   (re),
      .o_flash_ee   (ee),
      .o_flash_addr (faddr),
      .o_flash_din  (fdin),
      .i_flash_dout (fdout)
   );

   // flash model
   logic [7:0] mem [256];
   initial for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
   always @(posedge clk) begin
      if (we) mem[faddr] = fdin;
      else if (ee) mem[faddr] = 8'hFF;
      if (re) fdout <= mem[faddr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   // monitor
   logic [7:0] ev_kind[$];
   logic [7:0] ev_addr[$];
   logic [7:0] ev_din[$];
   int         ev_cyc[$];
   int cs_falls = 0, cs_fall_cyc = 0, hi_run = 0, last_hi_run = 0;
   int done_cnt = 0, done_cyc = 0, err_cnt = 0, err_cyc = 0, idle_cyc = 0;
   logic prev_cs = 1'b1, prev_busy = 1'b0;

   always @(negedge clk) begin
      checks++;
      if ((int'(we) + int'(re) + int'(ee)) > 1 || ((we | re | ee) && cs_n)) begin
         errors++;
         $display("FAIL strobe_protocol cyc=%0d got cs_n=%b we=%b re=%b ee=%b required onehot strobes with cs_n=0",
                  cyc, cs_n, we, re, ee);
      end
      if (we | re | ee) begin
         ev_kind.push_back(we ? "W" : (re ? "R" : "E"));
         ev_addr.push_back(faddr);
         ev_din.push_back(fdin);
         ev_cyc.push_back(cyc);
      end
      if (cs_n) hi_run++;
      else begin
         if (prev_cs) begin
            cs_falls++;
            cs_fall_cyc = cyc;
            last_hi_run = hi_run;
         end
         hi_run = 0;
      end
      prev_cs = cs_n;
      if (bus.done) begin done_cnt++; done_cyc = cyc; end
      if (bus.err) begin err_cnt++; err_cyc = cyc; end
      if (prev_busy && !bus.busy) idle_cyc = cyc;
      prev_busy = bus.busy;
   end

   // write-byte feeder: gap = cycles of wr_valid low before this byte
   typedef struct { logic [7:0] d; int gap; } wb_t;
   wb_t wq[$];
   always @(negedge clk) begin
      if (wq.size() > 0 && wq[0].gap > 0) begin
         bus.wr_valid = 1'b0;
         wq[0].gap = wq[0].gap - 1;
      end else if (wq.size() > 0) begin
         bus.wr_valid = 1'b1;
         bus.wr_data  = wq[0].d;
         if (bus.wr_ready) void'(wq.pop_front());
      end else begin
         bus.wr_valid = 1'b0;
         bus.wr_data  = 8'h00;
      end
   end

   // read-byte consumer with one optional stall
   logic [7:0] rxq[$];
   int         rxc[$];
   int   rx_idx = 0, stall_idx = -1, stall_cnt = 0;
   logic stalled = 1'b0;
   logic [7:0] st_data = 8'h00;
   always @(negedge clk) begin
      if (stalled) begin
         checks++;
         if (bus.rd_valid !== 1'b1 || bus.rd_data !== st_data) begin
            errors++;
            $display("FAIL rd_hold cyc=%0d got valid=%b data=%02h required valid=1 data=%02h",
                     cyc, bus.rd_valid, bus.rd_data, st_data);
         end
      end
      stalled = 1'b0;
      if (bus.rd_valid) begin
         if (rx_idx == stall_idx && stall_cnt > 0) begin
            bus.rd_ready = 1'b0;
            stall_cnt--;
            stalled = 1'b1;
            st_data = bus.rd_data;
         end else begin
            bus.rd_ready = 1'b1;
            rxq.push_back(bus.rd_data);
            rxc.push_back(cyc);
            rx_idx++;
         end
      end else begin
         bus.rd_ready = 1'b0;
      end
   end

   task automatic clear_logs();
      ev_kind.delete(); ev_addr.delete(); ev_din.delete(); ev_cyc.delete();
      rxq.delete(); rxc.delete(); rx_idx = 0;
   endtask

   // present a command from a negedge; acc = cycle whose closing edge accepts
   task automatic issue(input logic [1:0] op, input logic [7:0] a,
                        input logic [3:0] l, output int acc);
      bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_len = l;
      bus.cmd_valid = 1'b1;
      acc = -1;
      for (int i = 0; i < 50; i++) begin
         if (bus.cmd_ready) begin acc = cyc; break; end
         @(negedge clk);
      end
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (acc < 0) begin
         errors++; checks++;
         $display("FAIL cmd_accept got no cmd_ready required acceptance within 50 cycles");
      end
   endtask

   task automatic wait_idle();
      int n;
      for (n = 0; n < 300; n++) begin
         if (!bus.busy) break;
         @(negedge clk);
      end
      if (n == 300) begin
         errors++; checks++;
         $display("FAIL idle_timeout got busy=1 required busy=0 within 300 cycles");
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.busy, bus.done, bus.err} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_ctrl got %b required 100000",
                  {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.busy, bus.done, bus.err});
      end
      checks++;
      if ({cs_n, we, re, ee} !== 4'b1000) begin
         errors++; $display("FAIL reset_flash got %b required 1000", {cs_n, we, re, ee});
      end
      checks++;
      if ({bus.rd_data, faddr, fdin} !== 24'h0) begin
         errors++; $display("FAIL reset_data got %06h required 000000", {bus.rd_data, faddr, fdin});
      end
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.cmd_ready !== 1'b1 || cs_n !== 1'b1) begin
         errors++; $display("FAIL reset_release got ready=%b cs_n=%b required 1 1", bus.cmd_ready, cs_n);
      end
   endtask

   task automatic test_write_read();
      int acc, d0;
      clear_logs();
      d0 = done_cnt;
      for (int i = 0; i < 4; i++) wq.push_back('{8'(8'hA0 + i), 0});
      issue(2'b01, 8'h10, 4'd3, acc);
      wait_idle();
      checks++;
      if (ev_kind.size() != 4) begin
         errors++; $display("FAIL wr_count got %0d required 4", ev_kind.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (ev_kind[i] !== "W" || ev_addr[i] !== 8'(16 + i) || ev_din[i] !== 8'(8'hA0 + i)) begin
               errors++;
               $display("FAIL wr_byte%0d got %s@%02h=%02h required W@%02h=%02h", i,
                        ev_kind[i], ev_addr[i], ev_din[i], 8'(16 + i), 8'(8'hA0 + i));
            end
         end
         checks++;
         if (cs_fall_cyc != acc + 1 || ev_cyc[0] != acc + 3) begin
            errors++;
            $display("FAIL wr_timing got csfall=%0d we0=%0d required %0d %0d",
                     cs_fall_cyc, ev_cyc[0], acc + 1, acc + 3);
         end
         checks++;
         if (ev_cyc[1] - ev_cyc[0] != 2) begin
            errors++; $display("FAIL wr_rate got %0d required 2", ev_cyc[1] - ev_cyc[0]);
         end
         checks++;
         if (done_cyc != ev_cyc[3] + 1 || idle_cyc != ev_cyc[3] + 3) begin
            errors++;
            $display("FAIL wr_desel got done=%0d idle=%0d required %0d %0d",
                     done_cyc, idle_cyc, ev_cyc[3] + 1, ev_cyc[3] + 3);
         end
      end
      checks++;
      if (done_cnt - d0 != 1) begin
         errors++; $display("FAIL wr_done got %0d required 1", done_cnt - d0);
      end

      clear_logs();
      issue(2'b00, 8'h10, 4'd3, acc);
      wait_idle();
      checks++;
      if (last_hi_run < 2) begin
         errors++; $display("FAIL cs_high_gap got %0d required >=2", last_hi_run);
      end
      checks++;
      if (rxq.size() != 4 || ev_kind.size() != 4) begin
         errors++; $display("FAIL rd_count got rx=%0d re=%0d required 4 4", rxq.size(), ev_kind.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (rxq[i] !== 8'(8'hA0 + i) || ev_kind[i] !== "R" || ev_addr[i] !== 8'(16 + i)) begin
               errors++;
               $display("FAIL rd_byte%0d got %02h %s@%02h required %02h R@%02h", i,
                        rxq[i], ev_kind[i], ev_addr[i], 8'(8'hA0 + i), 8'(16 + i));
            end
         end
         checks++;
         if (ev_cyc[0] != acc + 2 || rxc[0] != ev_cyc[0] + 2 || ev_cyc[1] - ev_cyc[0] != 3) begin
            errors++;
            $display("FAIL rd_timing got re0=%0d rv0=%0d re1=%0d required %0d %0d %0d",
                     ev_cyc[0], rxc[0], ev_cyc[1], acc + 2, acc + 4, acc + 5);
         end
         checks++;
         if (idle_cyc != ev_cyc[3] + 5) begin
            errors++; $display("FAIL rd_desel got %0d required %0d", idle_cyc, ev_cyc[3] + 5);
         end
      end
   endtask

   task automatic test_wrap();
      int acc;
      clear_logs();
      wq.push_back('{8'h5A, 0});
      wq.push_back('{8'h5B, 0});
      issue(2'b01, 8'hFF, 4'd1, acc);
      wait_idle();
      checks++;
      if (ev_kind.size() != 2) begin
         errors++; $display("FAIL wrap_count got %0d required 2", ev_kind.size());
      end else begin
         checks++;
         if (ev_addr[0] !== 8'hFF || ev_din[0] !== 8'h5A || ev_addr[1] !== 8'h00 || ev_din[1] !== 8'h5B) begin
            errors++;
            $display("FAIL wrap_addr got %02h=%02h %02h=%02h required FF=5A 00=5B",
                     ev_addr[0], ev_din[0], ev_addr[1], ev_din[1]);
         end
      end
      clear_logs();
      issue(2'b00, 8'h00, 4'd0, acc);
      wait_idle();
      checks++;
      if (rxq.size() != 1 || rxq[0] !== 8'h5B) begin
         errors++; $display("FAIL wrap_read got n=%0d d=%02h required 1 5B", rxq.size(), rxq[0]);
      end
   endtask

   task automatic test_erase();
      int acc;
      logic [7:0] exp [4];
      exp = '{8'hA0, 8'hFF, 8'hFF, 8'hA3};
      clear_logs();
      issue(2'b10, 8'h11, 4'd1, acc);
      wait_idle();
      checks++;
      if (ev_kind.size() != 2) begin
         errors++; $display("FAIL er_count got %0d required 2", ev_kind.size());
      end else begin
         checks++;
         if (ev_kind[0] !== "E" || ev_kind[1] !== "E" || ev_addr[0] !== 8'h11 || ev_addr[1] !== 8'h12) begin
            errors++;
            $display("FAIL er_addr got %s@%02h %s@%02h required E@11 E@12",
                     ev_kind[0], ev_addr[0], ev_kind[1], ev_addr[1]);
         end
         checks++;
         if (ev_cyc[0] != acc + 2 || ev_cyc[1] != acc + 3 || idle_cyc != acc + 6) begin
            errors++;
            $display("FAIL er_timing got %0d %0d idle=%0d required %0d %0d %0d",
                     ev_cyc[0], ev_cyc[1], idle_cyc, acc + 2, acc + 3, acc + 6);
         end
      end
      clear_logs();
      issue(2'b00, 8'h10, 4'd3, acc);
      wait_idle();
      checks++;
      if (rxq.size() != 4) begin
         errors++; $display("FAIL er_read_count got %0d required 4", rxq.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (rxq[i] !== exp[i]) begin
               errors++; $display("FAIL er_read%0d got %02h required %02h", i, rxq[i], exp[i]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int acc, f0;
      logic [7:0] exp [4];
      exp = '{8'hA0, 8'hFF, 8'hFF, 8'hA3};
      clear_logs();
      f0 = cs_falls;
      stall_idx = 1; stall_cnt = 5;
      issue(2'b00, 8'h10, 4'd3, acc);
      wait_idle();
      stall_idx = -1;
      checks++;
      if (rxq.size() != 4 || ev_kind.size() != 4) begin
         errors++; $display("FAIL bp_rd_count got rx=%0d re=%0d required 4 4", rxq.size(), ev_kind.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (rxq[i] !== exp[i]) begin
               errors++; $display("FAIL bp_rd%0d got %02h required %02h", i, rxq[i], exp[i]);
            end
         end
         checks++;
         if (ev_cyc[1] - ev_cyc[0] != 3 || ev_cyc[2] - ev_cyc[1] != 8) begin
            errors++;
            $display("FAIL bp_rd_gap got %0d %0d required 3 8", ev_cyc[1] - ev_cyc[0], ev_cyc[2] - ev_cyc[1]);
         end
      end
      checks++;
      if (cs_falls - f0 != 1) begin
         errors++; $display("FAIL bp_rd_cs got %0d falls required 1", cs_falls - f0);
      end

      clear_logs();
      f0 = cs_falls;
      wq.push_back('{8'h11, 0});
      wq.push_back('{8'h22, 3});
      wq.push_back('{8'h33, 0});
      issue(2'b01, 8'h20, 4'd2, acc);
      wait_idle();
      checks++;
      if (ev_kind.size() != 3) begin
         errors++; $display("FAIL bp_wr_count got %0d required 3", ev_kind.size());
      end else begin
         checks++;
         if (ev_addr[0] !== 8'h20 || ev_din[0] !== 8'h11 || ev_addr[1] !== 8'h21 || ev_din[1] !== 8'h22 ||
             ev_addr[2] !== 8'h22 || ev_din[2] !== 8'h33) begin
            errors++;
            $display("FAIL bp_wr_data got %02h=%02h %02h=%02h %02h=%02h required 20=11 21=22 22=33",
                     ev_addr[0], ev_din[0], ev_addr[1], ev_din[1], ev_addr[2], ev_din[2]);
         end
         checks++;
         if (ev_cyc[1] - ev_cyc[0] != 4 || ev_cyc[2] - ev_cyc[1] != 2) begin
            errors++;
            $display("FAIL bp_wr_gap got %0d %0d required 4 2", ev_cyc[1] - ev_cyc[0], ev_cyc[2] - ev_cyc[1]);
         end
      end
      checks++;
      if (cs_falls - f0 != 1) begin
         errors++; $display("FAIL bp_wr_cs got %0d falls required 1", cs_falls - f0);
      end
   endtask

   task automatic test_reserved();
      int acc, e0, d0, f0;
      clear_logs();
      e0 = err_cnt; d0 = done_cnt; f0 = cs_falls;
      issue(2'b11, 8'h33, 4'd2, acc);
      repeat (4) @(negedge clk);
      checks++;
      if (err_cnt - e0 != 1 || err_cyc != acc + 1) begin
         errors++;
         $display("FAIL rsv_err got n=%0d cyc=%0d required 1 %0d", err_cnt - e0, err_cyc, acc + 1);
      end
      checks++;
      if (done_cnt != d0 || cs_falls != f0 || ev_kind.size() != 0) begin
         errors++;
         $display("FAIL rsv_quiet got done=%0d csfall=%0d strobes=%0d required 0 0 0",
                  done_cnt - d0, cs_falls - f0, ev_kind.size());
      end
   endtask

   task automatic test_reset_mid();
      int acc, d0, n;
      clear_logs();
      d0 = done_cnt;
      for (int i = 0; i < 4; i++) wq.push_back('{8'(8'hC0 + i), 0});
      issue(2'b01, 8'h40, 4'd3, acc);
      for (n = 0; n < 50 && ev_kind.size() < 2; n++) @(negedge clk);
      checks++;
      if (n == 50 || cs_n !== 1'b0) begin
         errors++; $display("FAIL mid_start got strobes=%0d cs_n=%b required 2 0", ev_kind.size(), cs_n);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.busy, bus.done, bus.err} !== 6'b100000 ||
          {cs_n, we, re, ee} !== 4'b1000) begin
         errors++;
         $display("FAIL mid_reset_ctrl got %b %b required 100000 1000",
                  {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.busy, bus.done, bus.err},
                  {cs_n, we, re, ee});
      end
      checks++;
      if ({bus.rd_data, faddr, fdin} !== 24'h0) begin
         errors++; $display("FAIL mid_reset_data got %06h required 000000", {bus.rd_data, faddr, fdin});
      end
      wq.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.cmd_ready !== 1'b1 || cs_n !== 1'b1 || done_cnt != d0) begin
         errors++;
         $display("FAIL mid_release got ready=%b cs_n=%b done=%0d required 1 1 0",
                  bus.cmd_ready, cs_n, done_cnt - d0);
      end
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_addr  = 8'h00;
      bus.cmd_len   = 4'd0;
      #1;
      @(negedge clk);
      test_reset();
      test_write_read();
      test_wrap();
      test_erase();
      test_backpressure();
      test_reserved();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
